// File: rtl/alu_pkg.sv
// Shared constants and decoded-instruction type for the ALU issue unit.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SRAI = 3'b110;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic        valid;
        logic [2:0]  sel;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 subset decoder: instruction word to ALU select, immediate and register fields.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_o     = '0;
        dec_o.rd  = instr_i[11:7];
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        case (opcode)
            OP_R: begin
                dec_o.valid = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_o.sel = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_o.sel = ALU_SUB;
                    {F7_BASE, 3'b111}: dec_o.sel = ALU_AND;
                    {F7_BASE, 3'b100}: dec_o.sel = ALU_XOR;
                    {F7_BASE, 3'b001}: dec_o.sel = ALU_SLL;
                    {F7_MUL,  3'b000}: dec_o.sel = ALU_MUL;
                    default:           dec_o.valid = 1'b0;
                endcase
            end
            OP_I: begin
                dec_o.use_imm = 1'b1;
                if (funct3 == 3'b000) begin
                    dec_o.valid = 1'b1;
                    dec_o.sel   = ALU_ADD;
                    dec_o.imm   = {{20{instr_i[31]}}, instr_i[31:20]};
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    // shamt is unsigned; only imm[4:0] reaches the shifter
                    dec_o.valid = 1'b1;
                    dec_o.sel   = ALU_SRAI;
                    dec_o.imm   = {27'b0, instr_i[24:20]};
                end
            end
            default: dec_o.valid = 1'b0;
        endcase
    end

    assign illegal_o = !dec_o.valid;

endmodule

// File: rtl/alu_issue.sv
// Two-stage decode/dispatch: forwards operands at accept, holds EX for multi-cycle mul,
// registers the ALU result and strobes a one-cycle register-file writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [2:0]  alu_sel_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        illegal_o
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    dec_t dec;
    logic dec_illegal;

    alu_decode u_decode (
        .instr_i   (instr_i),
        .dec_o     (dec),
        .illegal_o (dec_illegal)
    );

    // vld_pipe[0] = EX stage valid, vld_pipe[1] = WB stage valid
    logic [1:0]  vld_pipe_q, vld_pipe_d;
    logic [2:0]  ex_sel_q, ex_sel_d;
    logic [31:0] ex_a_q, ex_a_d;
    logic [31:0] ex_b_q, ex_b_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;

    logic        ex_done;
    logic        accept;
    logic [31:0] op1, op2;

    assign ex_done       = vld_pipe_q[0] && (cnt_q == 4'd0);
    assign instr_ready_o = !vld_pipe_q[0] || ex_done;
    assign accept        = instr_valid_i && instr_ready_o;

    assign rs1_addr_o = dec.rs1;
    assign rs2_addr_o = dec.rs2;

    // EX result beats WB data: it is the younger producer of the same register
    always_comb begin
        op1 = rs1_data_i;
        if (dec.rs1 != 5'd0) begin
            if (vld_pipe_q[0] && ex_rd_q == dec.rs1)
                op1 = alu_result_i;
            else if (vld_pipe_q[1] && wb_rd_q == dec.rs1)
                op1 = wb_data_q;
        end
        op2 = rs2_data_i;
        if (dec.rs2 != 5'd0) begin
            if (vld_pipe_q[0] && ex_rd_q == dec.rs2)
                op2 = alu_result_i;
            else if (vld_pipe_q[1] && wb_rd_q == dec.rs2)
                op2 = wb_data_q;
        end
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        ex_sel_d   = ex_sel_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_rd_d    = ex_rd_q;
        cnt_d      = cnt_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = accept && dec_illegal;

        if (ex_done)
            vld_pipe_d[0] = 1'b0;
        else if (vld_pipe_q[0])
            cnt_d = cnt_q - 4'd1;

        if (accept && dec.valid) begin
            vld_pipe_d[0] = 1'b1;
            ex_sel_d      = dec.sel;
            ex_a_d        = op1;
            ex_b_d        = dec.use_imm ? dec.imm : op2;
            ex_rd_d       = dec.rd;
            cnt_d         = (dec.sel == ALU_MUL) ? MUL_LOAD : 4'd0;
        end

        vld_pipe_d[1] = ex_done;
        if (ex_done) begin
            wb_rd_d   = ex_rd_q;
            wb_data_d = alu_result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_pipe_q <= '0;
            ex_sel_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rd_q    <= '0;
            cnt_q      <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            ex_sel_q   <= ex_sel_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_rd_q    <= ex_rd_d;
            cnt_q      <= cnt_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_sel_o  = ex_sel_q;
    assign alu_a_o    = ex_a_q;
    assign alu_b_o    = ex_b_q;
    assign wb_valid_o = vld_pipe_q[1] && (wb_rd_q != 5'd0);
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign illegal_o  = illegal_q;

endmodule
